mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequential arbiter that shares the single unified memory port between the instruction-fetch stage and the data-memory (load/store) stage of the RV64I pipeline. Runs one transaction at a time through a small FSM. Data accesses have priority, bounded by a fetch anti-starvation counter. Supports killing an in-flight fetch on a taken branch or jump. Generates per-stage one-cycle acks that the hazard logic uses to hold the front of the pipeline.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; the strobe width is DATA_W/8
- STARVE_LIMIT, 4, number of consecutive data grants allowed while fetch is waiting before fetch is forced to win; must be ≥1

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack or if_flush
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  kill the current or pending fetch (taken branch or jump)
- if_ack  out  1  one-cycle pulse when fetch data is valid
- if_rdata  out  DATA_W  fetch data; held until the next if_ack
- dm_req  in  1  data request; held high until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wstrb  in  DATA_W/8  byte enables
- dm_ack  out  1  one-cycle pulse when the data transaction completes
- dm_rdata  out  DATA_W  load data; held until the next dm_ack
- mem_req  out  1  memory request valid
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- mem_ready  in  1  memory accepts the request in the cycle when mem_req & mem_ready
- mem_rvalid  in  1  response valid; exactly one per accepted request, loads and stores alike
- mem_rdata  in  DATA_W  response data
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: mem_req high, wait for mem_ready.
  - WAIT: wait for mem_rvalid.
  - RESP: one cycle, pulse ack.
- Arbitration happens in IDLE only. Order of checks:
  - dm_req wins, unless if_req is high and starve_cnt == STARVE_LIMIT; then fetch wins.
  - Otherwise if_req wins if present (and if_flush is low).
  - With no valid request, stay in IDLE.
- At grant, latch owner (IF/DM), we, addr, wdata and wstrb into the mem_* registers. For a fetch grant, force mem_we = 0 and mem_wstrb = 0. Next state is ISSUE.
- starve_cnt (saturating):
  - increments on each DM grant while if_req is high;
  - clears on any IF grant and whenever if_req is low in IDLE.
- ISSUE: on mem_ready, go to WAIT. mem_req is high only in ISSUE.
- WAIT: on mem_rvalid, capture mem_rdata into the owner's rdata register and go to RESP. mem_rvalid is ignored in every other state.
- RESP: assert the owner's ack for one cycle, then go to IDLE. No arbitration in RESP, so a requester still holding req during its ack cycle is not re-granted.
- if_flush while the fetch is the owner:
  - In ISSUE, if mem_ready is low: drop the request and return to IDLE; no ack.
  - In ISSUE with mem_ready high, or in WAIT: set discard. The response is still consumed, but in RESP there is no if_ack and if_rdata is not updated.
  - In RESP: suppress if_ack.
- if_flush in IDLE blocks a fetch grant that cycle. if_flush has no effect on a DM-owned transaction.
- Reset (asynchronous, at any time, including mid-transaction):
  - state = IDLE; all outputs = 0 (mem_req, acks, busy, rdata, mem_* fields); starve_cnt = 0; discard = 0.
  - The memory model shares rst; there is no response after reset.

## Timing
- Minimum latency from grant to ack is 3 cycles:
  - request seen in IDLE at cycle 0;
  - mem_req at cycle 1 (ready in the same cycle);
  - rvalid at cycle 2;
  - ack at cycle 3.
- Each wait cycle on mem_ready or mem_rvalid adds one cycle.
- Back-to-back transactions cost one IDLE cycle. Period is 4 cycles at zero memory wait.
- mem_* outputs are registered and stay stable throughout ISSUE.
- Acks are registered single-cycle pulses. rdata is valid in the ack cycle and holds afterwards.

## Test plan
- Single fetch:
  - Stimulus: if_req, addr 0x1000; memory ready immediately; rvalid the next cycle with rdata 0x00500093.
  - Required: mem_req at cycle 1; if_ack and if_rdata = 0x00500093 at cycle 3; busy low at cycle 4.
- Store priority:
  - Stimulus: if_req and dm_req (we=1, addr 0x2000, wdata 0xDEADBEEF, wstrb 0x0F) asserted together.
  - Required: DM is granted first; mem_wstrb = 0x0F; dm_ack comes first; fetch is issued afterwards and ack'd 4 cycles later.
- Starvation:
  - Stimulus: if_req held while 6 loads are requested back-to-back, with STARVE_LIMIT = 4.
  - Required: grant order DM, DM, DM, DM, IF, DM, DM.
- Flush in ISSUE:
  - Stimulus: fetch granted, mem_ready held low 2 cycles, if_flush pulsed in the second cycle.
  - Required: mem_req drops the next cycle; no if_ack; IDLE is reached.
- Flush in WAIT:
  - Stimulus: flush after the fetch is accepted; rvalid arrives with 0x1234.
  - Required: no if_ack; if_rdata keeps its prior value.
- Reset mid-WAIT:
  - Stimulus: assert rst asynchronously during a load.
  - Required: all outputs 0 immediately; starve_cnt = 0; the next request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port between instruction fetch (IF) and
// the load/store stage (DM). One transaction is in flight at a time, walked
// through IDLE -> ISSUE -> WAIT -> RESP. Data accesses win arbitration unless
// fetch has been waiting through STARVE_LIMIT consecutive data grants. A
// taken branch/jump can kill an outstanding fetch via if_flush.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack or if_flush)
//   if_flush            kill current or pending fetch
//   if_ack/if_rdata     one-cycle fetch completion pulse, data held after
//   dm_req/dm_we/...    load/store request (held until dm_ack)
//   dm_ack/dm_rdata     one-cycle data completion pulse, data held after
//   mem_req/mem_*       registered request to memory, valid in ISSUE only
//   mem_ready           memory accepts when mem_req & mem_ready
//   mem_rvalid/rdata    one response per accepted request
//   busy                high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_ack,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state;
    logic             owner_dm;   // 1: data stage owns the transaction
    logic             discard;    // fetch response must be swallowed
    logic [CNT_W-1:0] starve_cnt;
    logic             if_ack_q;

    logic             fetch_ok;
    logic             grant_if;
    logic             grant_dm;
    logic             flush_fetch;

    // A flushed fetch is not eligible this cycle; if fetch is forced by the
    // starvation counter but flushed, a pending data request still goes.
    always_comb begin
        fetch_ok = if_req & ~if_flush;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            if (fetch_ok && (!dm_req || starve_cnt == CNT_MAX)) begin
                grant_if = 1'b1;
            end else if (dm_req) begin
                grant_dm = 1'b1;
            end
        end
    end

    assign flush_fetch = if_flush & ~owner_dm;
    assign busy        = (state != IDLE);

    // The registered ack is masked by a flush arriving in the RESP cycle so
    // the front end never consumes a fetch it has just killed.
    assign if_ack = if_ack_q & ~if_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner_dm   <= 1'b0;
            discard    <= 1'b0;
            starve_cnt <= '0;
            if_ack_q   <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack   <= 1'b0;

            // Counts data grants that overtook a waiting fetch; saturates.
            if (state == IDLE) begin
                if (grant_if || !if_req) begin
                    starve_cnt <= '0;
                end else if (grant_dm && starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (grant_if || grant_dm) begin
                        owner_dm  <= grant_dm;
                        discard   <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_addr  <= grant_dm ? dm_addr : if_addr;
                        mem_we    <= grant_dm & dm_we;
                        mem_wdata <= grant_dm ? dm_wdata : '0;
                        mem_wstrb <= grant_dm ? dm_wstrb : STRB_W'(0);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush_fetch && !mem_ready) begin
                        // Not yet accepted: the request can simply be withdrawn.
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (mem_ready) begin
                        // Accepted: a response is owed, so it must be drained.
                        mem_req <= 1'b0;
                        state   <= WAIT;
                        if (flush_fetch) begin
                            discard <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state   <= RESP;
                        discard <= 1'b0;
                        if (owner_dm) begin
                            dm_rdata <= mem_rdata;
                            dm_ack   <= 1'b1;
                        end else if (!(discard || if_flush)) begin
                            if_rdata <= mem_rdata;
                            if_ack_q <= 1'b1;
                        end
                    end else if (flush_fetch) begin
                        discard <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
